prbs_seq_ctrl: RTL

//  Test sequencer for the PRBS-15 / byte-sequence-detector path.
//  - On start: emits a 32-bit marker pattern, MSB byte first, a programmable number of times.
//  - Then forwards PRBS_BYTES bytes from the PRBS-15 generator.
//  - Watches the detector flag and reports pass/fail.
//  - Sits between the PRBS generator and the detector byte input; it owns the detector's data stream.

---
 rtl/prbs_seq_ctrl.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/prbs_seq_ctrl.sv
// prbs_seq_ctrl: test sequencer for the PRBS-15 / byte-sequence-detector path.
// On start it emits a 32-bit marker (MSB byte first) a programmable number of
// times. It then forwards PRBS_BYTES generator bytes and waits a bounded time
// for the detector flag. A one-cycle report with pass/fail follows.
// Optional feature macro: PRBS_SEQ_CTRL_ABORT_EN adds an abort input that cuts
// any running sequence short with a failing report.
module prbs_seq_ctrl #(
    parameter logic [31:0] PATTERN    = 32'hCCDDEEFF,
    parameter int          PRBS_BYTES = 16,
    parameter int          TIMEOUT    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] n,
    input  logic [7:0] prbs_byte,
    input  logic       det_flag,
`ifdef PRBS_SEQ_CTRL_ABORT_EN
    input  logic       abort,
`endif
    output logic       prbs_en,
    output logic [7:0] byte_out,
    output logic       byte_vld,
    output logic       busy,
    output logic       done,
    output logic       pass
);

    localparam int CW = $clog2(PRBS_BYTES + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PATTERN = 3'd1;
    localparam logic [2:0] S_PRBS    = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_REPORT  = 3'd4;

    // Marker byte selected by the 2-bit byte index, MSB byte first.
    function automatic logic [7:0] pat_byte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = PATTERN[31:24];
            2'd1:    b = PATTERN[23:16];
            2'd2:    b = PATTERN[15:8];
            default: b = PATTERN[7:0];
        endcase
        return b;
    endfunction

    logic [2:0]    r_state;
    logic [1:0]    r_idx;
    logic [2:0]    r_rep;
    logic [2:0]    r_reps;
    logic [CW-1:0] r_cnt;
    logic [TW-1:0] r_tmr;
    logic          r_det_seen;
    logic [7:0]    r_byte_out;
    logic          r_byte_vld;
    logic          r_busy;
    logic          r_done;
    logic          r_pass;

    logic [2:0]    w_state_nxt;
    logic [1:0]    w_idx_nxt;
    logic [2:0]    w_rep_nxt;
    logic [2:0]    w_reps_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [TW-1:0] w_tmr_nxt;
    logic          w_det_nxt;
    logic [7:0]    w_byte_nxt;
    logic          w_vld_nxt;
    logic          w_done_nxt;
    logic          w_pass_nxt;
    logic          w_det_live;
    logic          w_abort;

`ifdef PRBS_SEQ_CTRL_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // Detector flag seen so far, including the flag of the current cycle.
    assign w_det_live = r_det_seen | det_flag;

    assign prbs_en  = (r_state == S_PRBS);
    assign byte_out = r_byte_out;
    assign byte_vld = r_byte_vld;
    assign busy     = r_busy;
    assign done     = r_done;
    assign pass     = r_pass;

    // Next-state and next-output computation for the sequencer FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_rep_nxt   = r_rep;
        w_reps_nxt  = r_reps;
        w_cnt_nxt   = r_cnt;
        w_tmr_nxt   = r_tmr;
        w_det_nxt   = r_det_seen;
        w_byte_nxt  = r_byte_out;
        w_vld_nxt   = r_byte_vld;
        w_done_nxt  = 1'b0;
        w_pass_nxt  = r_pass;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_reps_nxt  = (n == 2'd0) ? 3'd4 : {1'b0, n};
                    w_det_nxt   = 1'b0;
                    w_pass_nxt  = 1'b0;
                    w_byte_nxt  = pat_byte(2'd0);
                    w_vld_nxt   = 1'b1;
                    w_idx_nxt   = 2'd1;
                    w_rep_nxt   = 3'd0;
                    w_cnt_nxt   = {CW{1'b0}};
                    w_tmr_nxt   = {TW{1'b0}};
                    w_state_nxt = S_PATTERN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_PATTERN: begin
                w_det_nxt = w_det_live;
                if (w_abort) begin
                    w_vld_nxt   = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_pass_nxt  = 1'b0;
                    w_state_nxt = S_REPORT;
                end else if ((r_idx == 2'd0) && (r_rep == r_reps)) begin
                    // All 4*reps marker bytes are out; first PRBS byte follows.
                    w_byte_nxt  = prbs_byte;
                    w_cnt_nxt   = CW'(1);
                    w_state_nxt = S_PRBS;
                end else begin
                    w_byte_nxt = pat_byte(r_idx);
                    w_idx_nxt  = r_idx + 2'd1;
                    if (r_idx == 2'd3) begin
                        w_rep_nxt = r_rep + 3'd1;
                    end else begin
                        w_rep_nxt = r_rep;
                    end
                end
            end
            S_PRBS: begin
                w_det_nxt = w_det_live;
                if (w_abort) begin
                    w_vld_nxt   = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_pass_nxt  = 1'b0;
                    w_state_nxt = S_REPORT;
                end else if (r_cnt == CW'(PRBS_BYTES)) begin
                    w_vld_nxt   = 1'b0;
                    w_tmr_nxt   = {TW{1'b0}};
                    w_state_nxt = S_WAIT;
                end else begin
                    w_byte_nxt = prbs_byte;
                    w_cnt_nxt  = r_cnt + CW'(1);
                end
            end
            S_WAIT: begin
                w_det_nxt = w_det_live;
                if (w_abort) begin
                    w_done_nxt  = 1'b1;
                    w_pass_nxt  = 1'b0;
                    w_state_nxt = S_REPORT;
                end else if (r_det_seen || (r_tmr == TW'(TIMEOUT - 1))) begin
                    // The flag of the final timer cycle still counts toward pass.
                    w_done_nxt  = 1'b1;
                    w_pass_nxt  = w_det_live;
                    w_state_nxt = S_REPORT;
                end else begin
                    w_tmr_nxt = r_tmr + TW'(1);
                end
            end
            S_REPORT: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_vld_nxt   = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; async active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_idx      <= 2'd0;
            r_rep      <= 3'd0;
            r_reps     <= 3'd0;
            r_cnt      <= {CW{1'b0}};
            r_tmr      <= {TW{1'b0}};
            r_det_seen <= 1'b0;
            r_byte_out <= 8'd0;
            r_byte_vld <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_rep      <= w_rep_nxt;
            r_reps     <= w_reps_nxt;
            r_cnt      <= w_cnt_nxt;
            r_tmr      <= w_tmr_nxt;
            r_det_seen <= w_det_nxt;
            r_byte_out <= w_byte_nxt;
            r_byte_vld <= w_vld_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
            r_done     <= w_done_nxt;
            r_pass     <= w_pass_nxt;
        end
    end

endmodule
